div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: operation and FSM encodings plus
// the fixed iteration count.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  localparam logic [5:0] IterCount = 6'd32;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    // Two extra bits so the borrow lands in the MSB for every legal operand pair.
    diff    = shifted - {2'b00, dvs_i};
    fits    = ~diff[WIDTH+1];
    rem_o   = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: 32 restoring iterations on operand magnitudes,
// with divide-by-zero and signed overflow resolved directly without iterating.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  import div_unit_pkg::*;

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  div_op_e          op_in;
  logic             in_signed, a_neg, b_neg, div_by_zero, overflow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_final, r_final;

  always_comb begin
    op_in       = div_op_e'(op);
    in_signed   = op_is_signed(op_in);
    a_neg       = in_signed & a[WIDTH-1];
    b_neg       = in_signed & b[WIDTH-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    div_by_zero = (b == '0);
    overflow    = in_signed & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
    q_final     = q_neg_q ? -quo_q : quo_q;
    r_final     = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_step),
    .quo_o(quo_step)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_in;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          if (div_by_zero) begin
            state_d  = StDone;
            result_d = op_is_rem(op_in) ? a : '1;
          end else if (overflow) begin
            state_d  = StDone;
            result_d = op_is_rem(op_in) ? '0 : a;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // The extra cycle at IterCount applies the sign fix-up into the result register.
        if (cnt_q == IterCount) begin
          state_d  = StDone;
          result_d = op_is_rem(op_q) ? r_final : q_final;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
